instruction_memory_sync: RTL and testbench
==========================================

# instruction_memory_sync

Parametrised, synchronous instruction memory for the RISC-V core's fetch stage. It replaces the combinational byte-array instruction store with a registered, handshaked read port, a word-write program-load port (bootloader/testbench loading instead of hard-coded init), alignment and range fault reporting, pipeline flush, and a fetch counter. It sits between the PC/fetch logic and the decode stage.

## Interface
Parameters:
- ADDR_WIDTH, 64, width of byte addresses (PC width).
- DEPTH_BYTES, 256, memory size in bytes; power of two, ≥ 8.
- NOP_INST, 32'h00000013, instruction returned on a faulted fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_addr  in  ADDR_WIDTH  byte address of instruction.
- rsp_valid  out  1  response holds a fetched instruction.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_inst  out  32  instruction, little-endian assembly of bytes addr..addr+3.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range (misaligned wins if both).
- flush  in  1  kill held response and block acceptance this cycle.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_WIDTH  byte address of word to write.
- prog_data  in  32  word to write (bits [7:0] to lowest byte).
- prog_err  out  1  one-cycle pulse: rejected program write.
- fetch_count  out  32  accepted, non-faulted fetches; saturates at 32'hFFFFFFFF.

## Operation
- Storage: DEPTH_BYTES/4 words of 32 bits; word index = addr[log2(DEPTH_BYTES)-1:2]. Contents are not cleared by reset and are retained across it.
- Fault check on req_addr: misaligned if addr[1:0] != 0; out of range if addr > DEPTH_BYTES-4 (full ADDR_WIDTH compare, so any set upper bit faults).
- Faulted fetch: rsp_inst = NOP_INST, rsp_fault set, memory not read, fetch_count unchanged.
- req_ready = !flush && (!rsp_valid || rsp_ready), combinational; no dependency on req_valid.
- Output register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY, accept -> FULL.
  - FULL, rsp_ready && accept -> FULL with new data.
  - FULL, rsp_ready && !accept -> EMPTY.
  - FULL, !rsp_ready -> FULL, rsp_inst/rsp_fault held stable.
  - flush (any state) -> EMPTY; no accept that cycle.
- Program write: accepted when prog_addr word-aligned and ≤ DEPTH_BYTES-4; otherwise ignored and prog_err pulses next cycle.
- Simultaneous prog_we and accepted fetch to the same word: fetch returns the old contents (read-before-write); new data visible to fetches accepted in later cycles.
- fetch_count increments once per accepted non-faulted request; holds at max.

## Timing
- Reset values: rsp_valid 0, rsp_inst 32'h0, rsp_fault 00, prog_err 0, fetch_count 0. Reset overrides flush, prog_we and req_valid; a program write in the reset cycle is dropped.
- Read latency 1: request accepted at edge N -> rsp_valid=1 with data after edge N.
- Throughput 1 fetch/cycle while rsp_ready held high.
- Write latency 1: write at edge N, readable by request accepted at edge N+1.
- prog_err high for exactly the cycle after the rejected write edge.
- flush at edge N: rsp_valid=0 after N; request presented in that cycle is not accepted and must be re-presented.

## Test plan
- Load words 0x10000913 @0, 0x00700993 @4, 0x07340663 @8; fetch 0,4,8 back-to-back with rsp_ready=1 -> rsp_valid from cycle after first accept, rsp_inst matches in order, rsp_fault=00, fetch_count=3.
- Fetch 0x2 -> rsp_fault=01, rsp_inst=0x00000013; fetch 0xFC (DEPTH 256) -> ok; fetch 0x100 and 0x1_0000_0000 -> rsp_fault=10; fetch_count counts only 0xFC.
- Response at 4 with rsp_ready=0 for 3 cycles -> rsp_inst=0x00700993 stable, req_ready=0; rsp_ready=1 with new request 8 -> next cycle shows 0x07340663.
- Same cycle: prog_we 0xDEADBEEF @4 and accepted fetch of 4 -> response 0x00700993; next fetch of 4 -> 0xDEADBEEF. prog_we @0x6 and @0x100 -> prog_err pulses one cycle each, memory unchanged.
- FULL response, assert flush with req_valid=1 -> req_ready=0, rsp_valid=0 next cycle, fetch_count unchanged.
- Mid-stream reset with rsp_valid=1 and fetch_count=5 -> all outputs at reset values next cycle; previously loaded words still read back correctly after reset.

Source files
------------

// File: rtl/instruction_memory_sync.sv
`default_nettype none
//==============================================================================
// Module      : instruction_memory_sync
// Description : Synchronous instruction memory for the fetch stage. Registered
//               handshaked read port, word-write program-load port, alignment
//               and range fault reporting, flush and a saturating fetch counter.
// Revision    : 1.0 - initial release
//==============================================================================
module instruction_memory_sync #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned DEPTH_BYTES = 256,
   parameter logic [31:0] NOP_INST    = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_inst,
   output logic [1:0]            rsp_fault,
   input  logic                  flush,
   input  logic                  prog_we,
   input  logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [31:0]           prog_data,
   output logic                  prog_err,
   output logic [31:0]           fetch_count
);

   localparam int unsigned         c_IDX_W     = $clog2(DEPTH_BYTES);
   localparam int unsigned         c_WORDS     = DEPTH_BYTES / 4;
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH_BYTES - 4);
   localparam logic [1:0]          c_FAULT_OK  = 2'b00;
   localparam logic [1:0]          c_FAULT_MIS = 2'b01;
   localparam logic [1:0]          c_FAULT_OOR = 2'b10;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_mem [c_WORDS];
   logic [31:0]           r_rsp_inst;
   logic [1:0]            r_rsp_fault;
   logic                  r_prog_err;
   logic [31:0]           r_fetch_count;

   logic                  w_accept;
   logic [1:0]            w_req_fault;
   logic [c_IDX_W-3:0]    w_req_idx;
   logic                  w_prog_ok;
   logic [c_IDX_W-3:0]    w_prog_idx;

   // Request decode: misalignment takes priority over out-of-range.
   always_comb begin
      w_req_fault = c_FAULT_OK;
      if (req_addr[1:0] != 2'b00) begin
         w_req_fault = c_FAULT_MIS;
      end else if (req_addr > c_LAST_ADDR) begin
         w_req_fault = c_FAULT_OOR;
      end
      w_req_idx  = req_addr[c_IDX_W-1:2];
      w_prog_ok  = (prog_addr[1:0] == 2'b00) && (prog_addr <= c_LAST_ADDR);
      w_prog_idx = prog_addr[c_IDX_W-1:2];
   end

   assign rsp_valid = (r_state == ST_FULL);
   assign req_ready = !flush && (!rsp_valid || rsp_ready);
   assign w_accept  = req_valid && req_ready;

   // Output register state: flush empties it and blocks acceptance.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (rsp_ready) w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Program-load write port; contents survive reset, writes during reset are dropped.
   always_ff @(posedge clk) begin
      if (!reset && prog_we && w_prog_ok) begin
         r_mem[w_prog_idx] <= prog_data;
      end
   end

   // Response data register; reading the old word gives read-before-write on a collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_inst  <= 32'h0;
         r_rsp_fault <= c_FAULT_OK;
      end else if (w_accept) begin
         r_rsp_fault <= w_req_fault;
         r_rsp_inst  <= (w_req_fault == c_FAULT_OK) ? r_mem[w_req_idx] : NOP_INST;
      end
   end

   // Rejected program writes pulse an error for exactly one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prog_err <= 1'b0;
      end else begin
         r_prog_err <= prog_we && !w_prog_ok;
      end
   end

   // Count accepted, non-faulted fetches, saturating at all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_count <= 32'h0;
      end else if (w_accept && (w_req_fault == c_FAULT_OK) &&
                   (r_fetch_count != 32'hFFFF_FFFF)) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign rsp_inst    = r_rsp_inst;
   assign rsp_fault   = r_rsp_fault;
   assign prog_err    = r_prog_err;
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_sync.sv
`default_nettype none
//==============================================================================
// Module      : tb_instruction_memory_sync
// Description : Directed self-checking bench for instruction_memory_sync.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_instruction_memory_sync;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_inst;
   logic [1:0]  rsp_fault;
   logic        flush;
   logic        prog_we;
   logic [63:0] prog_addr;
   logic [31:0] prog_data;
   logic        prog_err;
   logic [31:0] fetch_count;

   int r_total;
   int r_bad;

   instruction_memory_sync #(
      .ADDR_WIDTH (64),
      .DEPTH_BYTES(256),
      .NOP_INST   (32'h00000013)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_inst   (rsp_inst),
      .rsp_fault  (rsp_fault),
      .flush      (flush),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_err   (prog_err),
      .fetch_count(fetch_count)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      r_total++;
      if (obs !== exp) begin
         r_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [63:0] a, input logic [31:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      step();
      prog_we = 1'b0;
   endtask

   task automatic fetch(input logic [63:0] a);
      req_valid = 1'b1; req_addr = a;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      r_total = 0; r_bad = 0;
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
      flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_inst",  rsp_inst, 0);
      chk("rst_fault", rsp_fault, 0);
      chk("rst_perr",  prog_err, 0);
      chk("rst_cnt",   fetch_count, 0);
      chk("rst_ready", req_ready, 1);

      // Program load
      load(64'h0,  32'h10000913);
      load(64'h4,  32'h00700993);
      load(64'h8,  32'h07340663);
      load(64'hFC, 32'h12345678);
      chk("load_perr", prog_err, 0);

      // Back-to-back fetches
      req_valid = 1'b1; req_addr = 64'h0; step();
      chk("b2b0_valid", rsp_valid, 1);
      chk("b2b0_inst", rsp_inst, 32'h10000913);
      req_addr = 64'h4; step();
      chk("b2b1_inst", rsp_inst, 32'h00700993);
      req_addr = 64'h8; step();
      chk("b2b2_inst", rsp_inst, 32'h07340663);
      chk("b2b2_fault", rsp_fault, 0);
      chk("b2b_cnt", fetch_count, 3);
      req_valid = 1'b0; step();
      chk("drain_valid", rsp_valid, 0);

      // Faults
      fetch(64'h2);
      chk("mis_fault", rsp_fault, 2'b01);
      chk("mis_inst", rsp_inst, 32'h00000013);
      fetch(64'hFC);
      chk("fc_fault", rsp_fault, 2'b00);
      chk("fc_inst", rsp_inst, 32'h12345678);
      fetch(64'h100);
      chk("oor_fault", rsp_fault, 2'b10);
      chk("oor_inst", rsp_inst, 32'h00000013);
      fetch(64'h1_0000_0000);
      chk("hi_fault", rsp_fault, 2'b10);
      fetch(64'h101);
      chk("both_fault", rsp_fault, 2'b01);
      chk("fault_cnt", fetch_count, 4);
      step();

      // Backpressure
      fetch(64'h4);
      chk("bp_inst0", rsp_inst, 32'h00700993);
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h8;
      #1;
      chk("bp_ready", req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_inst", rsp_inst, 32'h00700993);
         chk("bp_hold_valid", rsp_valid, 1);
      end
      chk("bp_cnt", fetch_count, 5);
      rsp_ready = 1'b1; step();
      chk("bp_next_inst", rsp_inst, 32'h07340663);
      chk("bp_next_cnt", fetch_count, 6);
      req_valid = 1'b0; step();

      // Read-before-write collision
      prog_we = 1'b1; prog_addr = 64'h4; prog_data = 32'hDEADBEEF;
      fetch(64'h4);
      prog_we = 1'b0;
      chk("rbw_old", rsp_inst, 32'h00700993);
      fetch(64'h4);
      chk("rbw_new", rsp_inst, 32'hDEADBEEF);

      // Rejected program writes
      load(64'h6, 32'hAAAA5555);
      chk("perr_mis", prog_err, 1);
      step();
      chk("perr_mis_clr", prog_err, 0);
      load(64'h100, 32'h5555AAAA);
      chk("perr_oor", prog_err, 1);
      step();
      chk("perr_oor_clr", prog_err, 0);
      fetch(64'h0);
      chk("perr_w0", rsp_inst, 32'h10000913);
      fetch(64'h4);
      chk("perr_w1", rsp_inst, 32'hDEADBEEF);
      chk("perr_cnt", fetch_count, 10);
      step();

      // Flush with a held response
      rsp_ready = 1'b0;
      fetch(64'h8);
      chk("fl_full", rsp_valid, 1);
      flush = 1'b1; req_valid = 1'b1; req_addr = 64'h0;
      #1;
      chk("fl_ready", req_ready, 0);
      step();
      flush = 1'b0; req_valid = 1'b0;
      chk("fl_valid", rsp_valid, 0);
      chk("fl_cnt", fetch_count, 11);

      // Mid-stream reset
      fetch(64'h0);
      chk("mr_full", rsp_valid, 1);
      reset = 1'b1; prog_we = 1'b1; prog_addr = 64'h8; prog_data = 32'hBAD0BAD0;
      req_valid = 1'b1; req_addr = 64'h4;
      step();
      reset = 1'b0; prog_we = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      chk("mr_valid", rsp_valid, 0);
      chk("mr_inst", rsp_inst, 0);
      chk("mr_fault", rsp_fault, 0);
      chk("mr_perr", prog_err, 0);
      chk("mr_cnt", fetch_count, 0);
      fetch(64'h8);
      chk("mr_keep8", rsp_inst, 32'h07340663);
      fetch(64'h0);
      chk("mr_keep0", rsp_inst, 32'h10000913);
      chk("mr_cnt2", fetch_count, 2);

      $display("test done: total=%0d bad=%0d", r_total, r_bad);
      $finish;
   end

endmodule
`default_nettype wire
